// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and the
// select code that steers the registered tx output.
package uart_pkg;

  // Frame-sequencing states of the transmit controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Source for the next value of the tx register.
  typedef enum logic [1:0] {
    SEL_HIGH = 2'b00,  // idle / stop level
    SEL_LOW  = 2'b01,  // start bit
    SEL_DATA = 2'b10   // current LSB of the shift register
  } tx_sel_e;

endpackage

// File: rtl/uart_tx_controller.sv
// Transmit sequencer: walks IDLE -> START -> DATA -> STOP, times each bit
// with the baud counter and tells the datapath when to load, when to shift
// and which level tx must take on the coming clock edge.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    start_i,
  output logic    load_o,
  output logic    shift_en_o,
  output tx_sel_e tx_sel_o
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(DATA_BITS - 1);

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              baud_done;

  assign baud_done = (baud_cnt_q == BAUD_LAST);

  // Next-state, counter updates and datapath controls for the coming edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    load_o     = 1'b0;
    shift_en_o = 1'b0;
    tx_sel_o   = SEL_HIGH;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Start bit appears on the same edge that captures the byte.
          load_o     = 1'b1;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
          tx_sel_o   = SEL_LOW;
        end
      end

      START: begin
        tx_sel_o = SEL_LOW;
        if (baud_done) begin
          baud_cnt_d = '0;
          state_d    = DATA;
          tx_sel_o   = SEL_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      DATA: begin
        tx_sel_o = SEL_DATA;
        if (baud_done) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = STOP;
            tx_sel_o  = SEL_HIGH;
          end else begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shift_en_o = 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      STOP: begin
        tx_sel_o = SEL_HIGH;
        if (baud_done) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!rst) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter top: 8N1 framing, LSB first, registered idle-high tx.
// Holds the payload shift register and the tx output register; sequencing
// lives in uart_tx_controller.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx
);

  logic                 load;
  logic                 shift_en;
  tx_sel_e              tx_sel;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  uart_tx_controller #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .load_o     (load),
    .shift_en_o (shift_en),
    .tx_sel_o   (tx_sel)
  );

  // Shift register next value: capture the byte on load, shift right per bit.
  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = data_in;
    end else if (shift_en) begin
      shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
    end
  end

  // tx mux, fed from the post-edge shift value so a new data bit appears on
  // the same edge that shifts it into position.
  always_comb begin
    case (tx_sel)
      SEL_HIGH: tx_d = 1'b1;
      SEL_LOW:  tx_d = 1'b0;
      SEL_DATA: tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Payload and serial-output registers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the shift register is cleared on reset even though a load always
    // precedes its use; this keeps post-reset state fully defined.
    if (!rst) begin
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter. Stimulus predicts which cycles
// start a frame and which byte it carries; a monitor decodes frames from tx
// and compares them against those predictions.
module tb_uart_transmitter;

  localparam int CPB       = 1;
  localparam int FRAME_LEN = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    int         load_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   free_at = 0;
  exp_t exp_q[$];

  logic samples[$];
  bit   collecting = 1'b0;
  int   frame_start = 0;

  uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs; predict a frame start when the line is free.
  task automatic drive(input logic r, input logic s, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst     = r;
    start   = s;
    data_in = d;
    if (!r) begin
      exp_q.delete();
      free_at = 0;
    end else if (s && (cyc + 1) >= free_at) begin
      e.data     = d;
      e.load_cyc = cyc + 1;
      exp_q.push_back(e);
      free_at = cyc + 1 + FRAME_LEN + 1;
    end
  endtask

  // Monitor: collect one frame's worth of tx samples after a falling start
  // bit, decode it at bit centres and compare with the oldest prediction.
  always @(negedge clk) begin
    logic [7:0] got;
    exp_t       e;
    if (!rst) begin
      check("tx_high_in_reset", {31'd0, tx}, 32'd1);
      collecting = 1'b0;
      samples.delete();
    end else begin
      if (!collecting) begin
        if (tx == 1'b0) begin
          collecting  = 1'b1;
          frame_start = cyc;
          samples.delete();
          samples.push_back(tx);
        end
      end else begin
        samples.push_back(tx);
      end
      if (collecting && samples.size() == FRAME_LEN) begin
        collecting = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = samples[(1 + i) * CPB + CPB / 2];
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: frame 0x%0h started at cycle %0d, none expected",
                   got, frame_start);
        end else begin
          e = exp_q.pop_front();
          check("frame_start_cycle", frame_start, e.load_cyc);
          check("start_bit", {31'd0, samples[CPB / 2]}, 32'd0);
          check("frame_data", {24'd0, got}, {24'd0, e.data});
          check("stop_bit", {31'd0, samples[9 * CPB + CPB / 2]}, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         waited;

    // Reset held with start=1: no frame, tx stays high.
    #1 rst = 1'b0;
    repeat (5) drive(1'b0, 1'b1, 8'h5A);

    // Single frame 0x81 right after release.
    drive(1'b1, 1'b1, 8'b1000_0001);
    repeat (14) drive(1'b1, 1'b0, 8'h00);

    // start held high: back-to-back frames, one idle cycle apart.
    repeat (3 * (FRAME_LEN + 1)) drive(1'b1, 1'b1, 8'b1000_1011);
    repeat (14) drive(1'b1, 1'b0, 8'h00);

    // data_in and start wiggled mid-frame must not disturb the byte in flight.
    drive(1'b1, 1'b1, 8'b1010_1010);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h00);
    repeat (6) drive(1'b1, 1'b0, 8'h00);
    repeat (14) drive(1'b1, 1'b0, 8'h00);

    // One-cycle start pulse: exactly one frame, then idle.
    drive(1'b1, 1'b1, 8'h3C);
    repeat (25) drive(1'b1, 1'b0, 8'hFF);

    // Reset during the 4th data bit (a 0 bit): tx must rise at once.
    drive(1'b1, 1'b1, 8'h00);
    repeat (4) drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    free_at = 0;
    #1 check("tx_high_on_async_reset", {31'd0, tx}, 32'd1);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    repeat (20) drive(1'b1, 1'b0, 8'hA5);
    check("no_frame_after_reset", collecting, 0);

    // Randomised traffic: bursts of held start, pulses and data churn.
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      drive(1'b1, ($urandom_range(0, 3) == 0), d);
    end
    repeat (30) begin
      d = 8'($urandom);
      drive(1'b1, 1'b1, d);
    end
    drive(1'b1, 1'b0, 8'h00);

    // Drain: wait a bounded time for every predicted frame to be seen.
    waited = 0;
    while ((exp_q.size() != 0 || collecting) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("all_frames_seen", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("idle_high_at_end", {31'd0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
